// File: rtl/lsu_mem_master.sv
// ---------------------------------------------------------------------------
// lsu_mem_master
//   Load/store unit memory master. Accepts one RV32I load or store request at
//   a time, range/legality checks it, performs the memory access over a simple
//   synchronous-write / combinational-read word port, and returns a single
//   cycle response. Sub-word stores are done as read-modify-write.
//
// Ports
//   CLK, RST           clock, asynchronous active-high reset
//   req_valid/ready    request handshake (ready only while idle)
//   req_we             1 = store, 0 = load
//   req_funct3         RV32I width/sign code
//   req_addr           byte address
//   req_wdata          store data, right-aligned
//   rsp_valid          one-cycle response strobe
//   rsp_rdata          extended load data (0 for stores and errors)
//   rsp_err            request failed, qualified by rsp_valid
//   A, WD, WE          memory word address, write data, write enable
//   RD                 memory read data for A (combinational)
//
// Configuration
//   LSU_MISALIGN_TRAP_EN  defined: misaligned half/word accesses are errors.
//                         undefined: misaligned low address bits are cleared.
//
// States
//   IDLE  | waiting for a request, req_ready=1
//   READ  | A driven, memory word captured at exit
//   WRITE | A/WD driven, WE=1 for this single cycle
//   RESP  | rsp_valid=1 for one cycle
// ---------------------------------------------------------------------------
module lsu_mem_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned LIMIT     = 4096
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] A,
    output logic [31:0] WD,
    output logic        WE,
    input  logic [31:0] RD
);

    localparam logic [31:0] LIMIT32 = 32'(LIMIT);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_MIS = 1'b1;
`else
    localparam bit TRAP_MIS = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state;
    logic        lat_we;
    logic [2:0]  lat_f3;
    logic [1:0]  lat_off;
    logic [15:0] lat_wdata;

    logic        legal;
    logic        oor;
    logic        mis;
    logic        acc_err;
    logic [31:0] ea;

    // Acceptance-time decode of the incoming request.
    always_comb begin
        legal = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: legal = 1'b1;
                default:                legal = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                default:                                legal = 1'b0;
            endcase
        end

        // Unsigned wrap makes addresses below BASE_ADDR land far above LIMIT.
        oor = (req_addr - BASE_ADDR) >= LIMIT32;

        mis = 1'b0;
        ea  = req_addr;
        case (req_funct3[1:0])
            2'b01: begin
                mis   = req_addr[0];
                ea[0] = 1'b0;
            end
            2'b10: begin
                mis     = |req_addr[1:0];
                ea[1:0] = 2'b00;
            end
            default: ;
        endcase

        acc_err = !legal || oor || (TRAP_MIS && mis);
    end

    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h0, b};
            3'b101:  r = {16'h0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w,
                                                input logic        half,
                                                input logic [1:0]  off,
                                                input logic [15:0] d);
        logic [31:0] r;
        r = w;
        if (half) begin
            if (off[1]) r[31:16] = d;
            else        r[15:0]  = d;
        end else begin
            case (off)
                2'd0:    r[7:0]   = d[7:0];
                2'd1:    r[15:8]  = d[7:0];
                2'd2:    r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end
        return r;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            A         <= 32'h0;
            WD        <= 32'h0;
            WE        <= 1'b0;
            lat_we    <= 1'b0;
            lat_f3    <= 3'b000;
            lat_off   <= 2'b00;
            lat_wdata <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        lat_we    <= req_we;
                        lat_f3    <= req_funct3;
                        lat_off   <= ea[1:0];
                        lat_wdata <= req_wdata[15:0];
                        if (acc_err) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (req_we && req_funct3[1:0] == 2'b10) begin
                            // Full-word store needs no read of the old word.
                            state <= WRITE;
                            A     <= {ea[31:2], 2'b00};
                            WD    <= req_wdata;
                            WE    <= 1'b1;
                        end else begin
                            state <= READ;
                            A     <= {ea[31:2], 2'b00};
                        end
                    end
                end
                READ: begin
                    if (!lat_we) begin
                        state     <= RESP;
                        A         <= 32'h0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= load_ext(RD, lat_f3, lat_off);
                    end else begin
                        // The old word is captured straight into WD, merged.
                        state <= WRITE;
                        WD    <= store_merge(RD, lat_f3[0], lat_off, lat_wdata);
                        WE    <= 1'b1;
                    end
                end
                WRITE: begin
                    state     <= RESP;
                    A         <= 32'h0;
                    WD        <= 32'h0;
                    WE        <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
